// File: rtl/spi_pkg.sv
// ============================================================================
//  spi_pkg
//  Shared SPI types: receive FSM state encoding, frame-length codes and a
//  helper that converts a length code to a bit count.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam logic [1:0] C_TRANS_8_BITS  = 2'b00;
    localparam logic [1:0] C_TRANS_16_BITS = 2'b01;
    localparam logic [1:0] C_TRANS_24_BITS = 2'b10;
    localparam logic [1:0] C_TRANS_32_BITS = 2'b11;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Number of bits in a frame for a given length code (8/16/24/32).
    function automatic logic [6:0] frame_bits(input logic [1:0] dtb);
        logic [6:0] bits;
        bits = 7'd8;
        case (dtb)
            C_TRANS_8_BITS:  bits = 7'd8;
            C_TRANS_16_BITS: bits = 7'd16;
            C_TRANS_24_BITS: bits = 7'd24;
            C_TRANS_32_BITS: bits = 7'd32;
            default:         bits = 7'd8;
        endcase
        return bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_rx_deser_if.sv
// ============================================================================
//  spi_rx_deser_if
//  Bundle of control, serial-input and output-handshake signals of the SPI
//  receive deserializer.
//  Ports (signals):
//    st_i, cpol_i, cpha_i, lsb_i, dtb_i  frame start and configuration
//    pos_edge_i, neg_edge_i, spi_miso_i  SCK edge strobes and serial data
//    busy_o, done_o                      status
//    rx_valid_o, rx_ready_i, rx_data_o   one-entry output handshake
//    ovr_o, ovr_clr_i                    sticky overrun and its clear
//  Modports: master drives inputs / observes outputs, slave is the receiver.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface spi_rx_deser_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  st_i;
    logic                  cpol_i;
    logic                  cpha_i;
    logic                  lsb_i;
    logic [1:0]            dtb_i;
    logic                  pos_edge_i;
    logic                  neg_edge_i;
    logic                  spi_miso_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  rx_valid_o;
    logic                  rx_ready_i;
    logic [DATA_WIDTH-1:0] rx_data_o;
    logic                  ovr_o;
    logic                  ovr_clr_i;

    modport master (
        output st_i, cpol_i, cpha_i, lsb_i, dtb_i,
        output pos_edge_i, neg_edge_i, spi_miso_i,
        output rx_ready_i, ovr_clr_i,
        input  busy_o, done_o, rx_valid_o, rx_data_o, ovr_o
    );

    modport slave (
        input  st_i, cpol_i, cpha_i, lsb_i, dtb_i,
        input  pos_edge_i, neg_edge_i, spi_miso_i,
        input  rx_ready_i, ovr_clr_i,
        output busy_o, done_o, rx_valid_o, rx_data_o, ovr_o
    );
endinterface

`default_nettype wire

// File: rtl/spi_define.sv
// ============================================================================
//  spi_define
//  Shared SPI macros: maximum data width and frame-length codes.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef SPI_DEFINE_SV
`define SPI_DEFINE_SV

`define SPI_DATA_WIDTH     32
`define SPI_TRANS_8_BITS   2'b00
`define SPI_TRANS_16_BITS  2'b01
`define SPI_TRANS_24_BITS  2'b10
`define SPI_TRANS_32_BITS  2'b11

`endif

`default_nettype wire

// File: rtl/spi_rx_obuf.sv
// ============================================================================
//  spi_rx_obuf
//  One-entry valid/ready holding register for received words.
//  A push into an empty buffer, or into a full buffer that is being popped
//  in the same cycle, loads the word. A push into a full, non-popped buffer
//  drops the new word and sets the sticky overrun flag.
//  Ports:
//    clk_i, rst_i      clock, synchronous active-high reset
//    push_i, push_data_i  word offered by the deserializer
//    ready_i           consumer accepts the held word
//    valid_o, data_o   held word
//    ovr_clr_i, ovr_o  overrun clear / sticky overrun flag
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module spi_rx_obuf #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_i,
    input  wire logic                  push_i,
    input  wire logic [DATA_WIDTH-1:0] push_data_i,
    input  wire logic                  ready_i,
    output logic                       valid_o,
    output logic [DATA_WIDTH-1:0]      data_o,
    input  wire logic                  ovr_clr_i,
    output logic                       ovr_o
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_ovr;

    logic w_pop;
    logic w_load;
    logic w_drop;

    assign w_pop  = r_valid && ready_i;
    // Loading is allowed whenever the slot is free by the next cycle.
    assign w_load = push_i && (!r_valid || w_pop);
    assign w_drop = push_i && r_valid && !ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= push_data_i;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end

            // Setting has priority over a simultaneous clear.
            if (w_drop) begin
                r_ovr <= 1'b1;
            end else if (ovr_clr_i) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign ovr_o   = r_ovr;

endmodule

`default_nettype wire

// File: rtl/spi_rx_deser.sv
// ============================================================================
//  spi_rx_deser
//  SPI master receive deserializer. Samples MISO on the mode-selected SCK
//  strobe, assembles right-aligned 8/16/24/32-bit frames and hands each one
//  to a one-entry output buffer with overrun detection.
//  Ports:
//    clk_i, rst_i  clock, synchronous active-high reset
//    bus (slave)   start/config, edge strobes, MISO, status, output handshake
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module spi_rx_deser
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input wire logic     clk_i,
    input wire logic     rst_i,
    spi_rx_deser_if.slave bus
);

    // Configuration captured at frame start
    logic                  r_cpol;
    logic                  r_cpha;
    logic                  r_lsb;
    logic [CNT_WIDTH-1:0]  r_len;

    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_done;

    state_t r_state;
    state_t w_state_nxt;

    logic                  w_strobe;
    logic                  w_sample;
    logic                  w_last;
    logic                  w_start;
    logic [CNT_WIDTH-1:0]  w_idx;
    logic [CNT_WIDTH-1:0]  w_frame_len;
    logic [DATA_WIDTH-1:0] w_shift_nxt;

    // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling.
    assign w_strobe    = (r_cpol ^ r_cpha) ? bus.neg_edge_i : bus.pos_edge_i;
    assign w_sample    = (r_state == SHIFT) && w_strobe && (r_cnt != '0);
    assign w_last      = w_sample && (r_cnt == CNT_WIDTH'(1));
    assign w_start     = (r_state == IDLE) && bus.st_i;
    assign w_frame_len = CNT_WIDTH'(frame_bits(bus.dtb_i));
    // LSB-first write position: counts up from 0 as cnt counts down.
    assign w_idx       = r_len - r_cnt;

    always_comb begin
        w_shift_nxt = r_shift;
        if (r_lsb) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (CNT_WIDTH'(i) == w_idx) begin
                    w_shift_nxt[i] = bus.spi_miso_i;
                end
            end
        end else begin
            w_shift_nxt = {r_shift[DATA_WIDTH-2:0], bus.spi_miso_i};
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.st_i) w_state_nxt = SHIFT;
            SHIFT:   if (w_last)   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.busy_o = (r_state == SHIFT);
        bus.done_o = r_done;
    end

    // ------------------------------------------------------------------
    // Configuration, counter and shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            r_lsb   <= 1'b0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_start) begin
                r_cpol  <= bus.cpol_i;
                r_cpha  <= bus.cpha_i;
                r_lsb   <= bus.lsb_i;
                r_len   <= w_frame_len;
                r_cnt   <= w_frame_len;
                r_shift <= '0;
            end else if (w_sample) begin
                r_cnt   <= r_cnt - CNT_WIDTH'(1);
                r_shift <= w_shift_nxt;
            end
        end
    end

    // The completed word (including the final bit) is pushed in the same
    // cycle as the final sample so it is visible together with done_o.
    spi_rx_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_last),
        .push_data_i (w_shift_nxt),
        .ready_i     (bus.rx_ready_i),
        .valid_o     (bus.rx_valid_o),
        .data_o      (bus.rx_data_o),
        .ovr_clr_i   (bus.ovr_clr_i),
        .ovr_o       (bus.ovr_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_spi_rx_deser.sv
// ============================================================================
//  tb_spi_rx_deser
//  Directed self-checking bench for spi_rx_deser.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_rx_deser;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    spi_rx_deser_if #(.DATA_WIDTH(32)) bus ();

    spi_rx_deser #(
        .DATA_WIDTH (32),
        .CNT_WIDTH  (6)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are read on the falling
    // edge, half a cycle after the rising edge that updates them.

    task automatic start_frame(input logic cpol, input logic cpha,
                               input logic lsb, input logic [1:0] dtb);
        @(negedge clk);
        bus.cpol_i = cpol;
        bus.cpha_i = cpha;
        bus.lsb_i  = lsb;
        bus.dtb_i  = dtb;
        bus.st_i   = 1'b1;
        @(negedge clk);
        bus.st_i   = 1'b0;
    endtask

    // One sample. With 'other' set, the non-selected strobe fires one cycle
    // earlier carrying the inverted bit, which must be ignored.
    task automatic send_bit(input logic b, input logic use_neg,
                            input logic other, input logic rdy);
        if (other) begin
            @(negedge clk);
            bus.spi_miso_i = ~b;
            if (use_neg) bus.pos_edge_i = 1'b1; else bus.neg_edge_i = 1'b1;
        end
        @(negedge clk);
        bus.pos_edge_i = 1'b0;
        bus.neg_edge_i = 1'b0;
        bus.spi_miso_i = b;
        bus.rx_ready_i = rdy;
        if (use_neg) bus.neg_edge_i = 1'b1; else bus.pos_edge_i = 1'b1;
        @(negedge clk);
        bus.pos_edge_i = 1'b0;
        bus.neg_edge_i = 1'b0;
        bus.rx_ready_i = 1'b0;
    endtask

    // Sends stream[hi] down to stream[lo], first bit = stream[hi].
    task automatic send_bits(input logic [31:0] stream, input int hi, input int lo,
                             input logic use_neg, input logic other,
                             input logic rdy_last);
        for (int i = hi; i >= lo; i--) begin
            send_bit(stream[i], use_neg, other, (i == lo) ? rdy_last : 1'b0);
        end
    endtask

    task automatic drain();
        @(negedge clk);
        bus.rx_ready_i = 1'b1;
        @(negedge clk);
        bus.rx_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy_o, bus.done_o, bus.rx_valid_o, bus.ovr_o} !== 4'b0000 ||
            bus.rx_data_o !== 32'h0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b valid=%b ovr=%b data=%h, expected all 0",
                     bus.busy_o, bus.done_o, bus.rx_valid_o, bus.ovr_o, bus.rx_data_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mode0_msb();
        start_frame(1'b0, 1'b0, 1'b0, 2'b00);
        checks++;
        if (bus.busy_o !== 1'b1) begin
            failures++;
            $display("FAIL mode0_busy: busy=%b expected 1", bus.busy_o);
        end
        send_bits(32'h000000CA, 7, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.done_o, bus.rx_valid_o, bus.busy_o} !== 3'b110 ||
            bus.rx_data_o !== 32'h000000CA) begin
            failures++;
            $display("FAIL mode0_msb: done=%b valid=%b busy=%b data=%h expected 1 1 0 000000ca",
                     bus.done_o, bus.rx_valid_o, bus.busy_o, bus.rx_data_o);
        end
        @(negedge clk);
        checks++;
        if (bus.done_o !== 1'b0 || bus.rx_valid_o !== 1'b1 ||
            bus.rx_data_o !== 32'h000000CA) begin
            failures++;
            $display("FAIL mode0_hold: done=%b valid=%b data=%h expected 0 1 000000ca",
                     bus.done_o, bus.rx_valid_o, bus.rx_data_o);
        end
        drain();
        checks++;
        if (bus.rx_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL mode0_pop: valid=%b expected 0", bus.rx_valid_o);
        end
    endtask

    task automatic test_lsb_interleave();
        start_frame(1'b0, 1'b0, 1'b1, 2'b00);
        send_bits(32'h000000CA, 7, 0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.done_o !== 1'b1 || bus.rx_data_o !== 32'h00000053) begin
            failures++;
            $display("FAIL lsb_interleave: done=%b data=%h expected 1 00000053",
                     bus.done_o, bus.rx_data_o);
        end
        drain();
    endtask

    task automatic test_mode3_32();
        start_frame(1'b1, 1'b1, 1'b0, 2'b11);
        send_bits(32'hDEADBEEF, 31, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.done_o !== 1'b1 || bus.rx_data_o !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL mode3_32: done=%b data=%h expected 1 deadbeef",
                     bus.done_o, bus.rx_data_o);
        end
        drain();
    endtask

    task automatic test_mode1_32();
        start_frame(1'b0, 1'b1, 1'b0, 2'b11);
        send_bits(32'hDEADBEEF, 31, 0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.done_o !== 1'b1 || bus.rx_data_o !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL mode1_32: done=%b data=%h expected 1 deadbeef",
                     bus.done_o, bus.rx_data_o);
        end
        drain();
    endtask

    task automatic test_overrun();
        start_frame(1'b0, 1'b0, 1'b0, 2'b00);
        send_bits(32'h00000011, 7, 0, 1'b0, 1'b0, 1'b0);
        start_frame(1'b0, 1'b0, 1'b0, 2'b00);
        send_bits(32'h00000022, 7, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.done_o !== 1'b1 || bus.rx_valid_o !== 1'b1 ||
            bus.rx_data_o !== 32'h00000011 || bus.ovr_o !== 1'b1) begin
            failures++;
            $display("FAIL overrun: done=%b valid=%b data=%h ovr=%b expected 1 1 00000011 1",
                     bus.done_o, bus.rx_valid_o, bus.rx_data_o, bus.ovr_o);
        end
        bus.ovr_clr_i = 1'b1;
        @(negedge clk);
        bus.ovr_clr_i = 1'b0;
        checks++;
        if (bus.ovr_o !== 1'b0) begin
            failures++;
            $display("FAIL ovr_clear: ovr=%b expected 0", bus.ovr_o);
        end
        drain();
    endtask

    task automatic test_pop_push();
        start_frame(1'b0, 1'b0, 1'b0, 2'b00);
        send_bits(32'h00000011, 7, 0, 1'b0, 1'b0, 1'b0);
        start_frame(1'b0, 1'b0, 1'b0, 2'b00);
        send_bits(32'h00000022, 7, 0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.rx_valid_o !== 1'b1 || bus.rx_data_o !== 32'h00000022 ||
            bus.ovr_o !== 1'b0) begin
            failures++;
            $display("FAIL pop_push: valid=%b data=%h ovr=%b expected 1 00000022 0",
                     bus.rx_valid_o, bus.rx_data_o, bus.ovr_o);
        end
        drain();
    endtask

    task automatic test_reset_midframe();
        start_frame(1'b0, 1'b0, 1'b0, 2'b01);
        send_bits(32'h0000FFFF, 15, 9, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.busy_o, bus.rx_valid_o, bus.done_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_midframe: busy=%b valid=%b done=%b expected 0 0 0",
                     bus.busy_o, bus.rx_valid_o, bus.done_o);
        end
        start_frame(1'b0, 1'b0, 1'b0, 2'b00);
        send_bits(32'h0000005A, 7, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.done_o !== 1'b1 || bus.rx_data_o !== 32'h0000005A) begin
            failures++;
            $display("FAIL after_reset: done=%b data=%h expected 1 0000005a",
                     bus.done_o, bus.rx_data_o);
        end
        drain();
    endtask

    task automatic test_ignore_midframe();
        start_frame(1'b0, 1'b0, 1'b0, 2'b10);
        send_bits(32'h00ABCDEF, 23, 12, 1'b0, 1'b0, 1'b0);
        // Restart attempt with a different length and polarity mid-frame
        @(negedge clk);
        bus.st_i   = 1'b1;
        bus.dtb_i  = 2'b00;
        bus.cpha_i = 1'b1;
        @(negedge clk);
        bus.st_i   = 1'b0;
        send_bits(32'h00ABCDEF, 11, 1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.busy_o !== 1'b1 || bus.done_o !== 1'b0 || bus.rx_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL ignore_23: busy=%b done=%b valid=%b expected 1 0 0",
                     bus.busy_o, bus.done_o, bus.rx_valid_o);
        end
        send_bits(32'h00ABCDEF, 0, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0 ||
            bus.rx_data_o !== 32'h00ABCDEF) begin
            failures++;
            $display("FAIL ignore_24: done=%b busy=%b data=%h expected 1 0 00abcdef",
                     bus.done_o, bus.busy_o, bus.rx_data_o);
        end
        checks++;
        if (bus.rx_data_o[31:24] !== 8'h00) begin
            failures++;
            $display("FAIL ignore_upper: upper=%h expected 00", bus.rx_data_o[31:24]);
        end
        drain();
    endtask

    task automatic test_idle_strobes();
        @(negedge clk);
        bus.pos_edge_i = 1'b1;
        bus.neg_edge_i = 1'b1;
        bus.spi_miso_i = 1'b1;
        repeat (3) @(negedge clk);
        bus.pos_edge_i = 1'b0;
        bus.neg_edge_i = 1'b0;
        checks++;
        if ({bus.busy_o, bus.done_o, bus.rx_valid_o} !== 3'b000) begin
            failures++;
            $display("FAIL idle_strobes: busy=%b done=%b valid=%b expected 0 0 0",
                     bus.busy_o, bus.done_o, bus.rx_valid_o);
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        bus.st_i       = 1'b0;
        bus.cpol_i     = 1'b0;
        bus.cpha_i     = 1'b0;
        bus.lsb_i      = 1'b0;
        bus.dtb_i      = 2'b00;
        bus.pos_edge_i = 1'b0;
        bus.neg_edge_i = 1'b0;
        bus.spi_miso_i = 1'b0;
        bus.rx_ready_i = 1'b0;
        bus.ovr_clr_i  = 1'b0;

        test_reset();
        test_mode0_msb();
        test_lsb_interleave();
        test_mode3_32();
        test_mode1_32();
        test_overrun();
        test_pop_push();
        test_reset_midframe();
        test_ignore_midframe();
        test_idle_strobes();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
